// File: rtl/mulseq_pkg.sv
// Shared widths, FSM state type and column-bound helpers for the limb-serial multiplier.
package mulseq_pkg;

  localparam int LIMB_W  = 17;
  localparam int ACC_W   = 48;
  localparam int DSP_A_W = 18;
  localparam int DSP_P_W = 2 * DSP_A_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  // First term index i of column k for an n-limb operand.
  function automatic int col_lo(input int k, input int n);
    return (k > n - 1) ? (k - n + 1) : 0;
  endfunction

  // Last term index i of column k; squaring keeps only i <= j.
  function automatic int col_hi(input int k, input int n, input logic sq_mode);
    int hi;
    hi = (k < n - 1) ? k : (n - 1);
    if (sq_mode && ((k / 2) < hi)) begin
      hi = k / 2;
    end
    return hi;
  endfunction

endpackage

// File: rtl/xilinxdspmuladd.sv
// Behavioural model of a single DSP slice: 18x18 multiply plus optional C / PCIN / PCIN>>17 addends.
module xilinxdspmuladd
  import mulseq_pkg::*;
(
  input  logic [DSP_A_W-1:0] dataA,
  input  logic [DSP_A_W-1:0] dataB,
  input  logic [ACC_W-1:0]   dataC,
  input  logic [ACC_W-1:0]   pcin,
  input  logic               doAddC,
  input  logic               doAddPcin,
  input  logic               doAddPcinShifted,
  output logic [ACC_W-1:0]   result
);

  logic [DSP_P_W-1:0] mul_p;

  always_comb begin
    mul_p  = dataA * dataB;
    result = {{(ACC_W - DSP_P_W){1'b0}}, mul_p};
    if (doAddC) begin
      result = result + dataC;
    end
    if (doAddPcin) begin
      result = result + pcin;
    end
    if (doAddPcinShifted) begin
      result = result + (pcin >> LIMB_W);
    end
  end

endmodule

// File: rtl/mulseq_ctrl.sv
// Column-ordered limb-serial multiplier: one partial product per cycle through a single DSP mul-add.
// Optional squaring schedule (i <= j terms only) enabled by defining MULSEQ_SQUARE_EN.
module mulseq_ctrl
  import mulseq_pkg::*;
#(
  parameter int NUM_LIMBS = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start_valid,
  output logic                            start_ready,
  input  logic [NUM_LIMBS*LIMB_W-1:0]     op_a,
  input  logic [NUM_LIMBS*LIMB_W-1:0]     op_b,
  input  logic                            sq,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [2*NUM_LIMBS*LIMB_W-1:0]   product,
  output logic                            busy
);

  localparam int OP_W   = NUM_LIMBS * LIMB_W;
  localparam int PROD_W = 2 * OP_W;
  localparam int KW     = $clog2(2 * NUM_LIMBS);
  localparam int LAST_K = 2 * NUM_LIMBS - 2;

  state_e              state_q, state_d;
  logic [KW-1:0]       k_q, k_d;
  logic [KW-1:0]       i_q, i_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [PROD_W-1:0]   prod_q, prod_d;
  logic [OP_W-1:0]     a_q, a_d;
  logic [OP_W-1:0]     b_q, b_d;
  logic                sq_mode;

  logic [DSP_A_W-1:0]  dsp_a;
  logic [DSP_A_W-1:0]  dsp_b;
  logic [ACC_W-1:0]    dsp_c;
  logic [ACC_W-1:0]    dsp_res;

  logic [LIMB_W-1:0]   a_limb;
  logic [LIMB_W-1:0]   b_limb;
  logic [OP_W-1:0]     b_src;
  logic                first_term;
  logic                last_term;
  int                  k_int;
  int                  i_int;
  int                  j_int;
  int                  lo_next;

`ifdef MULSEQ_SQUARE_EN
  logic sq_q, sq_d;

  always_comb begin
    sq_d = sq_q;
    if ((state_q == IDLE) && start_valid) begin
      sq_d = sq;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sq_q <= 1'b0;
    end else begin
      sq_q <= sq_d;
    end
  end

  assign sq_mode = sq_q;
`else
  logic unused_sq;
  assign unused_sq = sq;
  assign sq_mode   = 1'b0;
`endif

  // Term decode: current (column, row) to limb operands and DSP inputs.
  always_comb begin
    k_int      = int'(k_q);
    i_int      = int'(i_q);
    j_int      = k_int - i_int;
    first_term = (i_int == col_lo(k_int, NUM_LIMBS));
    last_term  = (i_int == col_hi(k_int, NUM_LIMBS, sq_mode));
    lo_next    = col_lo(k_int + 1, NUM_LIMBS);

    b_src  = sq_mode ? a_q : b_q;
    a_limb = a_q[i_int*LIMB_W +: LIMB_W];
    b_limb = b_src[j_int*LIMB_W +: LIMB_W];

    // Off-diagonal square terms appear twice in the full product, so fold the x2 into dataA.
    if (sq_mode && (i_int != j_int)) begin
      dsp_a = {a_limb, 1'b0};
    end else begin
      dsp_a = {1'b0, a_limb};
    end
    dsp_b = {1'b0, b_limb};

    // Opening a new column carries the previous column's upper bits forward.
    if (first_term && (k_q != '0)) begin
      dsp_c = acc_q >> LIMB_W;
    end else begin
      dsp_c = acc_q;
    end
  end

  xilinxdspmuladd u_dsp (
    .dataA            (dsp_a),
    .dataB            (dsp_b),
    .dataC            (dsp_c),
    .pcin             ({ACC_W{1'b0}}),
    .doAddC           (1'b1),
    .doAddPcin        (1'b0),
    .doAddPcinShifted (1'b0),
    .result           (dsp_res)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    i_d     = i_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    a_d     = a_q;
    b_d     = b_q;

    unique case (state_q)
      IDLE: begin
        if (start_valid) begin
          a_d     = op_a;
          b_d     = op_b;
          acc_d   = '0;
          prod_d  = '0;
          k_d     = '0;
          i_d     = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        acc_d = dsp_res;
        if (first_term && (k_q != '0)) begin
          prod_d[(k_int-1)*LIMB_W +: LIMB_W] = acc_q[LIMB_W-1:0];
        end
        if (last_term) begin
          if (k_int == LAST_K) begin
            state_d = FLUSH;
          end else begin
            k_d = k_q + KW'(1);
            i_d = KW'(lo_next);
          end
        end else begin
          i_d = i_q + KW'(1);
        end
      end

      FLUSH: begin
        prod_d[LAST_K*LIMB_W +: LIMB_W]     = acc_q[LIMB_W-1:0];
        prod_d[(LAST_K+1)*LIMB_W +: LIMB_W] = acc_q[2*LIMB_W-1:LIMB_W];
        state_d                             = DONE;
      end

      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      i_q     <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      i_q     <= i_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign res_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign product     = prod_q;

endmodule

// File: tb/tb_mulseq_ctrl.sv
// Directed-vector and random-operand bench for mulseq_ctrl at NUM_LIMBS=4.
module tb_mulseq_ctrl;

  localparam int N    = 4;
  localparam int OPW  = N * 17;
  localparam int PW   = 2 * OPW;
`ifdef MULSEQ_SQUARE_EN
  localparam bit SQ_EN = 1'b1;
`else
  localparam bit SQ_EN = 1'b0;
`endif
  localparam int LAT_FULL = 17;
  localparam int LAT_SQ   = SQ_EN ? 11 : 17;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start_valid = 1'b0;
  logic           start_ready;
  logic [OPW-1:0] op_a = '0;
  logic [OPW-1:0] op_b = '0;
  logic           sq = 1'b0;
  logic           res_valid;
  logic           res_ready = 1'b0;
  logic [PW-1:0]  product;
  logic           busy;

  int checks_total  = 0;
  int checks_passed = 0;

  mulseq_ctrl #(.NUM_LIMBS(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .sq          (sq),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .product     (product),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
    logic           s;
    logic [PW-1:0]  exp_p;
    int             exp_lat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    checks_total++;
    if (got === exp) begin
      checks_passed++;
    end else begin
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and wait for res_valid; lat counts edges after the accepting edge.
  task automatic start_wait(input logic [OPW-1:0] a, input logic [OPW-1:0] b, input logic s,
                            output int lat);
    int guard;
    guard = 0;
    while (!start_ready && guard < 50) begin
      tick();
      guard++;
    end
    chk("start_ready_before_request", PW'(start_ready), PW'(1));
    op_a = a;
    op_b = b;
    sq = s;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    op_a = '0;
    op_b = '0;
    sq = 1'b0;
    lat = 0;
    while (!res_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic consume();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  function automatic logic [PW-1:0] ref_mul(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                                             input logic s);
    logic [PW-1:0] aa;
    logic [PW-1:0] bb;
    aa = PW'(a);
    bb = (SQ_EN && s) ? PW'(a) : PW'(b);
    return aa * bb;
  endfunction

  function automatic logic [OPW-1:0] rnd_op();
    logic [OPW-1:0] v;
    v = '0;
    for (int l = 0; l < N; l++) begin
      case ($urandom_range(0, 3))
        0:       v[l*17 +: 17] = 17'h0;
        1:       v[l*17 +: 17] = 17'h1FFFF;
        default: v[l*17 +: 17] = 17'($urandom);
      endcase
    end
    return v;
  endfunction

  initial begin
    logic [OPW-1:0] ones;
    logic [PW-1:0]  ones_sq;
    logic [PW-1:0]  held;
    logic [OPW-1:0] ra;
    logic [OPW-1:0] rb;
    logic           rs;
    int             lat;

    ones    = {OPW{1'b1}};
    ones_sq = PW'(0) - (PW'(1) << 69) + PW'(1);

    vecs[0] = '{a: OPW'(1), b: OPW'(1), s: 1'b0, exp_p: PW'(1), exp_lat: LAT_FULL};
    vecs[1] = '{a: ones, b: ones, s: 1'b0, exp_p: ones_sq, exp_lat: LAT_FULL};
    vecs[2] = '{a: ones, b: OPW'(0), s: 1'b1, exp_p: SQ_EN ? ones_sq : PW'(0), exp_lat: LAT_SQ};
    vecs[3] = '{a: OPW'(3), b: OPW'(5), s: 1'b0, exp_p: PW'(15), exp_lat: LAT_FULL};
    vecs[4] = '{a: OPW'(1) << 17, b: OPW'(1) << 51, s: 1'b0, exp_p: PW'(1) << 68, exp_lat: LAT_FULL};
    vecs[5] = '{a: OPW'(17'h1FFFF), b: OPW'(17'h1FFFF), s: 1'b0, exp_p: PW'(36'h3_FFFC_0001),
                exp_lat: LAT_FULL};
    vecs[6] = '{a: OPW'(12345), b: OPW'(99), s: 1'b1,
                exp_p: SQ_EN ? PW'(152399025) : PW'(1222155), exp_lat: LAT_SQ};
    vecs[7] = '{a: OPW'(0), b: ones, s: 1'b0, exp_p: PW'(0), exp_lat: LAT_FULL};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", PW'(busy), PW'(0));
    chk("reset_res_valid", PW'(res_valid), PW'(0));
    chk("reset_start_ready", PW'(start_ready), PW'(1));
    chk("reset_product", product, PW'(0));
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Directed table
    for (int v = 0; v < 8; v++) begin
      start_wait(vecs[v].a, vecs[v].b, vecs[v].s, lat);
      chk($sformatf("vec%0d_latency", v), PW'(lat), PW'(vecs[v].exp_lat));
      chk($sformatf("vec%0d_product", v), product, vecs[v].exp_p);
      consume();
    end

    // Hold result under back-pressure while a stray request is presented.
    start_wait(ones, ones, 1'b0, lat);
    held = product;
    for (int c = 0; c < 5; c++) begin
      start_valid = (c == 2);
      op_a = OPW'(7);
      op_b = OPW'(9);
      tick();
      chk($sformatf("hold%0d_res_valid", c), PW'(res_valid), PW'(1));
      chk($sformatf("hold%0d_product", c), product, ones_sq);
      chk($sformatf("hold%0d_start_ready", c), PW'(start_ready), PW'(0));
    end
    chk("hold_product_unchanged", product, held);

    // A request coincident with consumption must not be taken on that edge.
    op_a = OPW'(3);
    op_b = OPW'(5);
    start_valid = 1'b1;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("consume_edge_busy", PW'(busy), PW'(0));
    chk("consume_edge_start_ready", PW'(start_ready), PW'(1));
    tick();
    start_valid = 1'b0;
    lat = 0;
    while (!res_valid && lat < 100) begin
      tick();
      lat++;
    end
    chk("after_consume_latency", PW'(lat), PW'(LAT_FULL));
    chk("after_consume_product", product, PW'(15));
    consume();

    // Asynchronous reset in the middle of RUN.
    op_a = ones;
    op_b = ones;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    repeat (8) tick();
    chk("pre_reset_busy", PW'(busy), PW'(1));
    reset = 1'b1;
    #1;
    chk("midrun_reset_busy", PW'(busy), PW'(0));
    chk("midrun_reset_res_valid", PW'(res_valid), PW'(0));
    chk("midrun_reset_start_ready", PW'(start_ready), PW'(1));
    chk("midrun_reset_product", product, PW'(0));
    @(negedge clk);
    reset = 1'b0;
    tick();
    start_wait(OPW'(3), OPW'(5), 1'b0, lat);
    chk("post_reset_latency", PW'(lat), PW'(LAT_FULL));
    chk("post_reset_product", product, PW'(15));
    consume();

    // Random operands with random result back-pressure.
    for (int r = 0; r < 1000; r++) begin
      ra = rnd_op();
      rb = rnd_op();
      rs = 1'($urandom_range(0, 1));
      start_wait(ra, rb, rs, lat);
      chk($sformatf("rand%0d_latency", r), PW'(lat), PW'((SQ_EN && rs) ? 11 : 17));
      repeat ($urandom_range(0, 3)) tick();
      chk($sformatf("rand%0d_product", r), product, ref_mul(ra, rb, rs));
      consume();
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
